mem_bus_responder: RTL and testbench

Memory-side responder for the CPU's 16-bit address / 8-bit data bus: accepts one read or write request at a time from the register-file/CPU side, decodes the Game Boy address map, services HRAM (FF80–FFFE) and the IE register (FFFF) internally, and forwards every other mapped access to an external memory port with a programmable wait count. It sits between the CPU core's address/data outputs and the cartridge/WRAM/VRAM/IO fabric. It returns read data with a one-cycle `ack` pulse.

---
 rtl/mem_bus_responder_pkg.sv | 50 +++++
 rtl/mem_bus_responder_if.sv | 31 +++
 rtl/mem_bus_responder_hram.sv | 25 ++
 rtl/mem_bus_responder.sv | 135 +++++++++++++
 tb/tb_mem_bus_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-side bus responder.
// Holds the FSM state type, the address-map region constants of the
// Game Boy memory map, and helpers that classify and remap a CPU address.
package gb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    REGION_EXT      = 2'd0,
    REGION_HRAM     = 2'd1,
    REGION_IE       = 2'd2,
    REGION_UNUSABLE = 2'd3
  } mem_region_t;

  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  localparam logic [15:0] HRAM_LAST     = 16'hFFFE;
  localparam logic [15:0] IE_ADDR       = 16'hFFFF;
  localparam logic [15:0] ECHO_BASE     = 16'hE000;
  localparam logic [15:0] ECHO_LAST     = 16'hFDFF;
  localparam logic [15:0] UNUSABLE_BASE = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_LAST = 16'hFEFF;
  localparam logic [15:0] ECHO_OFFSET   = 16'h2000;

  // Everything not claimed by an internal region goes out to the fabric.
  function automatic mem_region_t decode_region(input logic [15:0] a);
    mem_region_t r;
    r = REGION_EXT;
    if (a == IE_ADDR)
      r = REGION_IE;
    else if (a >= HRAM_BASE && a <= HRAM_LAST)
      r = REGION_HRAM;
    else if (a >= UNUSABLE_BASE && a <= UNUSABLE_LAST)
      r = REGION_UNUSABLE;
    return r;
  endfunction

  // Echo RAM mirrors work RAM, so it is folded back before leaving the block.
  function automatic logic [15:0] remap_ext(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    if (a >= ECHO_BASE && a <= ECHO_LAST)
      r = a - ECHO_OFFSET;
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Bus bundle between the CPU-side requester, the responder and the
// external memory fabric.
//   CPU side : req, we, addr, wr_data (to responder); rd_data, ack, bus_err
//   Ext side : ext_cs, ext_we, ext_addr, ext_wdata (from responder); ext_rdata
// master = requester/test side, slave = the responder.
interface mem_bus_responder_if;
  import gb_mem_pkg::*;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ack;
  logic        bus_err;
  logic        ext_cs;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;

  modport master (
    output req, we, addr, wr_data, ext_rdata,
    input  rd_data, ack, bus_err, ext_cs, ext_we, ext_addr, ext_wdata
  );

  modport slave (
    input  req, we, addr, wr_data, ext_rdata,
    output rd_data, ack, bus_err, ext_cs, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mem_bus_responder_hram.sv
// 127x8 high RAM storage (FF80-FFFE).
// Ports: clk (clock), we_i (write enable), idx_i (addr[6:0]),
//        wdata_i (write data), rdata_o (combinational read data).
// Contents are deliberately not reset. Index 127 belongs to the IE
// register, so it is never written here and reads back as zero.
module hram_127x8
  import gb_mem_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [6:0] idx_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [0:126];

  always_ff @(posedge clk) begin
    if (we_i && idx_i != 7'h7F)
      mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = (idx_i == 7'h7F) ? 8'h00 : mem_q[idx_i];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the 16-bit address / 8-bit data CPU bus.
// Ports: clk (rising-edge clock), rst (async active-low reset),
//        bus (slave modport: CPU request/response and external memory port).
// Serves HRAM and IE internally, flags the unusable FEA0-FEFF window, and
// forwards everything else to the external port for EXT_WAIT+1 cycles.
// All outputs come straight from registers.
module mem_bus_responder
  import gb_mem_pkg::*;
#(
  parameter int EXT_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_responder_if.slave bus
);

  localparam int CNT_W = (EXT_WAIT > 0) ? $clog2(EXT_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXT_WAIT);

  mem_state_t       state_q;
  logic [CNT_W-1:0] waitCnt_q;
  logic             ack_q;
  logic             busErr_q;
  logic             extCs_q;
  logic             extWe_q;
  logic [15:0]      extAddr_q;
  logic [7:0]       extWdata_q;
  logic [7:0]       rdData_q;
  logic [7:0]       ie_q;

  mem_region_t region_d;
  logic        hramWe_d;
  logic [7:0]  hramRdata_d;

  // The request is decoded as it is accepted so internal accesses can
  // complete in the very next cycle.
  assign region_d = decode_region(bus.addr);
  assign hramWe_d = (state_q == IDLE) && bus.req && bus.we && (region_d == REGION_HRAM);

  hram_127x8 u_hram (
    .clk     (clk),
    .we_i    (hramWe_d),
    .idx_i   (bus.addr[6:0]),
    .wdata_i (bus.wr_data),
    .rdata_o (hramRdata_d)
  );

  // Responder FSM. Internal accesses commit on the accept edge and go
  // straight to DONE; external ones latch address/data into the ext_*
  // registers, which keeps them stable however the requester's inputs move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      ack_q      <= 1'b0;
      busErr_q   <= 1'b0;
      extCs_q    <= 1'b0;
      extWe_q    <= 1'b0;
      extAddr_q  <= 16'h0000;
      extWdata_q <= 8'h00;
      rdData_q   <= 8'h00;
      ie_q       <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q    <= 1'b0;
          busErr_q <= 1'b0;
          if (bus.req) begin
            case (region_d)
              REGION_HRAM: begin
                if (!bus.we)
                  rdData_q <= hramRdata_d;
                ack_q   <= 1'b1;
                state_q <= DONE;
              end
              REGION_IE: begin
                if (bus.we)
                  ie_q <= bus.wr_data;
                else
                  rdData_q <= ie_q;
                ack_q   <= 1'b1;
                state_q <= DONE;
              end
              REGION_UNUSABLE: begin
                if (!bus.we)
                  rdData_q <= 8'hFF;
                ack_q    <= 1'b1;
                busErr_q <= 1'b1;
                state_q  <= DONE;
              end
              default: begin
                extCs_q    <= 1'b1;
                extWe_q    <= bus.we;
                extAddr_q  <= remap_ext(bus.addr);
                extWdata_q <= bus.wr_data;
                waitCnt_q  <= '0;
                state_q    <= EXT;
              end
            endcase
          end
        end
        EXT: begin
          if (waitCnt_q == CNT_LAST) begin
            // extWe_q still holds the latched direction on the final cycle.
            if (!extWe_q)
              rdData_q <= bus.ext_rdata;
            extCs_q <= 1'b0;
            extWe_q <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            waitCnt_q <= waitCnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          ack_q    <= 1'b0;
          busErr_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.bus_err   = busErr_q;
  assign bus.rd_data   = rdData_q;
  assign bus.ext_cs    = extCs_q;
  assign bus.ext_we    = extWe_q;
  assign bus.ext_addr  = extAddr_q;
  assign bus.ext_wdata = extWdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder. A behavioural model of the
// address map (HRAM array, IE byte, last read value) predicts every
// response; directed cases cover the boundaries, then random traffic.
module tb_mem_bus_responder;

  localparam int EXT_WAIT = 2;
  localparam int RG_EXT = 0;
  localparam int RG_HRAM = 1;
  localparam int RG_IE = 2;
  localparam int RG_BAD = 3;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  logic [7:0] hramModel [0:126];
  bit         writtenModel [0:126];
  logic [7:0] ieModel;
  logic [7:0] rdModel;

  mem_bus_responder_if bus ();

  mem_bus_responder #(.EXT_WAIT(EXT_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guards against a hung simulation if the DUT never returns to IDLE.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Address map straight from the memory map table.
  function automatic int regionOf(input logic [15:0] a);
    if (a == 16'hFFFF) return RG_IE;
    if (a >= 16'hFF80) return RG_HRAM;
    if (a >= 16'hFEA0 && a <= 16'hFEFF) return RG_BAD;
    return RG_EXT;
  endfunction

  function automatic logic [15:0] extAddrOf(input logic [15:0] a);
    if (a >= 16'hE000 && a <= 16'hFDFF) return a - 16'h2000;
    return a;
  endfunction

  // One transaction. Entered at a negedge while the DUT is idle; returns at
  // the negedge of the idle cycle after completion. keepReq leaves req high
  // across the ack edge so the caller can chain a back-to-back request.
  task automatic applyStimulus(input logic isWrite, input logic [15:0] a, input logic [7:0] wd, input bit keepReq);
    int         region;
    int         lat;
    int         expLat;
    int         csCycles;
    int         expCs;
    bit         done;
    logic [7:0] extVal;
    logic [15:0] expAddr;
    logic [15:0] seenAddr;
    logic       seenWe;
    logic [7:0] seenWd;
    logic       errSeen;
    logic [7:0] rdSeen;

    region   = regionOf(a);
    expAddr  = extAddrOf(a);
    extVal   = 8'($urandom);
    expLat   = (region == RG_EXT) ? EXT_WAIT + 2 : 1;
    expCs    = (region == RG_EXT) ? EXT_WAIT + 1 : 0;
    lat      = 0;
    csCycles = 0;
    done     = 0;
    seenAddr = expAddr;
    seenWe   = isWrite;
    seenWd   = wd;
    errSeen  = 1'b0;
    rdSeen   = 8'h00;

    case (region)
      RG_HRAM: begin
        if (isWrite) begin
          hramModel[a - 16'hFF80] = wd;
          writtenModel[a - 16'hFF80] = 1;
        end else begin
          rdModel = hramModel[a - 16'hFF80];
        end
      end
      RG_IE: begin
        if (isWrite) ieModel = wd;
        else rdModel = ieModel;
      end
      RG_BAD: begin
        if (!isWrite) rdModel = 8'hFF;
      end
      default: begin
        if (!isWrite) rdModel = extVal;
      end
    endcase

    bus.req     = 1'b1;
    bus.we      = isWrite;
    bus.addr    = a;
    bus.wr_data = wd;
    @(posedge clk);

    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (bus.ext_cs) begin
        csCycles++;
        if (bus.ext_addr !== expAddr) seenAddr = bus.ext_addr;
        if (bus.ext_we !== isWrite) seenWe = bus.ext_we;
        if (isWrite && bus.ext_wdata !== wd) seenWd = bus.ext_wdata;
        bus.addr    = 16'($urandom);
        bus.we      = 1'($urandom);
        bus.wr_data = 8'($urandom);
      end
      bus.ext_rdata = (n == EXT_WAIT + 1) ? extVal : 8'($urandom);
      if (bus.ack) begin
        lat     = n;
        errSeen = bus.bus_err;
        rdSeen  = bus.rd_data;
        done    = 1;
        if (!keepReq) bus.req = 1'b0;
      end
    end

    checkOutput($sformatf("latency@%h", a), lat, expLat);
    if (done) begin
      checkOutput($sformatf("rd_data@%h", a), rdSeen, rdModel);
      checkOutput($sformatf("bus_err@%h", a), errSeen, (region == RG_BAD) ? 1 : 0);
    end
    checkOutput($sformatf("ext_cycles@%h", a), csCycles, expCs);
    if (region == RG_EXT) begin
      checkOutput($sformatf("ext_addr@%h", a), seenAddr, expAddr);
      checkOutput($sformatf("ext_we@%h", a), seenWe, isWrite);
      if (isWrite) checkOutput($sformatf("ext_wdata@%h", a), seenWd, wd);
    end

    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("ack_gap@%h", a), bus.ack, 0);
    checkOutput($sformatf("cs_gap@%h", a), bus.ext_cs, 0);
  endtask

  initial begin
    int ackSeen;

    compared    = 0;
    mismatched  = 0;
    ieModel     = 8'h00;
    rdModel     = 8'h00;
    for (int i = 0; i < 127; i++) begin
      hramModel[i]    = 8'h00;
      writtenModel[i] = 0;
    end
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.addr      = 16'h0000;
    bus.wr_data   = 8'h00;
    bus.ext_rdata = 8'h00;
    rst           = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ack", bus.ack, 0);
    checkOutput("reset_ext_cs", bus.ext_cs, 0);
    checkOutput("reset_rd_data", bus.rd_data, 8'h00);
    checkOutput("reset_ext_addr", bus.ext_addr, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_ack", bus.ack, 0);
    checkOutput("idle_bus_err", bus.bus_err, 0);
    checkOutput("idle_ext_we", bus.ext_we, 0);
    checkOutput("idle_ext_wdata", bus.ext_wdata, 8'h00);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 16'hFFFF, 8'h00, 0);
    applyStimulus(1'b1, 16'hFF80, 8'h5A, 0);
    applyStimulus(1'b1, 16'hFFFE, 8'hA5, 0);
    applyStimulus(1'b1, 16'hFF81, 8'h81, 0);
    applyStimulus(1'b0, 16'hFF80, 8'h00, 0);
    applyStimulus(1'b0, 16'hFFFE, 8'h00, 0);
    applyStimulus(1'b0, 16'hE123, 8'h00, 0);
    applyStimulus(1'b0, 16'hFEA0, 8'h00, 0);
    applyStimulus(1'b1, 16'hFEFF, 8'h12, 0);
    applyStimulus(1'b1, 16'hC000, 8'h77, 1);
    applyStimulus(1'b0, 16'hFF81, 8'h00, 0);
    applyStimulus(1'b0, 16'hFF7F, 8'h00, 0);
    applyStimulus(1'b0, 16'hFE00, 8'h00, 0);
    applyStimulus(1'b0, 16'hFE9F, 8'h00, 0);
    applyStimulus(1'b1, 16'hFDFF, 8'h3D, 0);
    applyStimulus(1'b1, 16'h2000, 8'h01, 0);
    applyStimulus(1'b1, 16'hFFFF, 8'hC3, 0);
    applyStimulus(1'b0, 16'hFFFF, 8'h00, 0);

    $display("[TB] random traffic");
    for (int t = 0; t < 60; t++) begin
      int         cat;
      logic [15:0] a;
      logic       w;
      logic [7:0] d;
      cat = $urandom_range(0, 5);
      w   = 1'($urandom);
      d   = 8'($urandom);
      case (cat)
        0: a = 16'hFF80 + 16'($urandom_range(0, 126));
        1: a = 16'hFFFF;
        2: a = 16'hFEA0 + 16'($urandom_range(0, 95));
        3: a = 16'hE000 + 16'($urandom_range(0, 16'h1DFF));
        default: a = 16'($urandom);
      endcase
      if (regionOf(a) == RG_HRAM && !w && !writtenModel[a - 16'hFF80]) w = 1'b1;
      applyStimulus(w, a, d, (t < 59) && ($urandom_range(0, 3) == 0));
    end

    $display("[TB] reset during external access");
    applyStimulus(1'b1, 16'hFFFF, 8'h9E, 0);
    bus.req     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = 16'hC010;
    bus.wr_data = 8'h99;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midext_cs_first", bus.ext_cs, 1);
    checkOutput("midext_we_first", bus.ext_we, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midext_cs_drop", bus.ext_cs, 0);
    checkOutput("midext_we_drop", bus.ext_we, 0);
    bus.req = 1'b0;
    ackSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack) ackSeen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack) ackSeen++;
    end
    checkOutput("midext_no_ack", ackSeen, 0);
    checkOutput("midext_rd_data", bus.rd_data, 8'h00);
    ieModel = 8'h00;
    rdModel = 8'h00;
    applyStimulus(1'b0, 16'hFFFF, 8'h00, 0);
    applyStimulus(1'b0, 16'hFF80, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
